// File: rtl/ook_rx_pkg.sv
// Shared types and constants for the OOK receive deframer.
package ook_rx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYNC_W = 16;
  localparam int unsigned ERR_W  = 2;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } rx_state_e;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_LEN     = 2'd1;
  localparam logic [ERR_W-1:0] ERR_CSUM    = 2'd2;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [SYNC_W-1:0] DEF_SYNC_WORD = 16'hA5C3;

  // 2-of-3 vote used by the mid-bit sampler
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ook_bit_sync.sv
// Bit recovery: input synchronizer, edge detect, phase counter and
// mid-bit majority sampler producing one bit_valid pulse per bit period.
module ook_bit_sync
  import ook_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk_system,
  input  logic g_reset_n,
  input  logic i_rx,
  output logic o_bit_value,
  output logic o_bit_valid,
  output logic o_edge_c
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_PRE  = PW'(OVERSAMPLE / 2 - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_dly;
  logic          r_samp_pre;
  logic          r_bit_value;
  logic          r_bit_valid;
  logic [PW-1:0] r_phase;
  logic          w_edge;

  assign w_edge = r_sync2 ^ r_dly;

  // The decision registered at the end of the mid phase uses sync stage 1
  // as the look-ahead sample, so bit_valid is visible during phase MID+1.
  // An edge in the mid cycle restarts the phase, so no bit is taken there.
  always_ff @(posedge clk_system or negedge g_reset_n) begin
    if (!g_reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_dly       <= 1'b0;
      r_samp_pre  <= 1'b0;
      r_bit_value <= 1'b0;
      r_bit_valid <= 1'b0;
      r_phase     <= '0;
    end else begin
      r_sync1     <= i_rx;
      r_sync2     <= r_sync1;
      r_dly       <= r_sync2;
      r_bit_valid <= 1'b0;

      if (w_edge || (r_phase == PH_LAST)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + PW'(1);
      end

      if (r_phase == PH_PRE) begin
        r_samp_pre <= r_sync2;
      end

      if ((r_phase == PH_MID) && !w_edge) begin
        r_bit_value <= maj3(r_samp_pre, r_sync2, r_sync1);
        r_bit_valid <= 1'b1;
      end
    end
  end

  assign o_bit_value = r_bit_value;
  assign o_bit_valid = r_bit_valid;
  assign o_edge_c    = w_edge;

endmodule

// File: rtl/ook_rx_deframer.sv
// OOK receive deframer: sync-word hunt, length/payload/checksum deframing,
// byte stream output and per-frame status with timeout supervision.
module ook_rx_deframer
  import ook_rx_pkg::*;
#(
  parameter int unsigned        OVERSAMPLE   = 8,
  parameter logic [SYNC_W-1:0]  SYNC_WORD    = DEF_SYNC_WORD,
  parameter int unsigned        MAX_LEN      = 64,
  parameter int unsigned        TIMEOUT_BITS = 32
) (
  input  logic             clk_system,
  input  logic             g_reset_n,
  input  logic             enable,
  input  logic             rx_in,
  output logic [BYTE_W-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_frame_ok,
  output logic [ERR_W-1:0] rx_err_code,
  output logic             rx_busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT_BITS - 1);
  localparam logic [BYTE_W-1:0] LEN_MAX = BYTE_W'(MAX_LEN);

  rx_state_e         r_state;
  logic [SYNC_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_byte;
  logic [2:0]        r_bitcnt;
  logic [BYTE_W-1:0] r_remain;
  logic [BYTE_W-1:0] r_csum;
  logic [TW-1:0]     r_to_cnt;

  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_sof;
  logic              r_eof;
  logic              r_frame_ok;
  logic [ERR_W-1:0]  r_err_code;
  logic              r_busy;

  logic              w_bit_value;
  logic              w_bit_valid;
  logic              w_edge;
  logic [SYNC_W-1:0] w_shift_next;
  logic [BYTE_W-1:0] w_byte_next;
  logic              w_byte_done;
  logic              w_timeout;

  ook_bit_sync #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_sync (
    .clk_system  (clk_system),
    .g_reset_n   (g_reset_n),
    .i_rx        (rx_in),
    .o_bit_value (w_bit_value),
    .o_bit_valid (w_bit_valid),
    .o_edge_c    (w_edge)
  );

  assign w_shift_next = {r_shift[SYNC_W-2:0], w_bit_value};
  assign w_byte_next  = {r_byte[BYTE_W-2:0], w_bit_value};
  assign w_byte_done  = w_bit_valid && (r_bitcnt == 3'd7);
  // Timeout takes priority over a byte completing on the same bit
  assign w_timeout    = w_bit_valid && !w_edge && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_system or negedge g_reset_n) begin
    if (!g_reset_n) begin
      r_state    <= HUNT;
      r_shift    <= '0;
      r_byte     <= '0;
      r_bitcnt   <= '0;
      r_remain   <= '0;
      r_csum     <= '0;
      r_to_cnt   <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_frame_ok <= 1'b0;
      r_err_code <= ERR_NONE;
      r_busy     <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_frame_ok <= 1'b0;
      r_err_code <= ERR_NONE;

      if (!enable) begin
        r_state  <= HUNT;
        r_busy   <= 1'b0;
        r_shift  <= '0;
        r_data   <= '0;
        r_to_cnt <= '0;
        r_bitcnt <= '0;
      end else begin
        if ((r_state == HUNT) || w_edge) begin
          r_to_cnt <= '0;
        end else if (w_bit_valid) begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end

        if (w_bit_valid) begin
          r_byte   <= w_byte_next;
          r_bitcnt <= r_bitcnt + 3'd1;
        end

        case (r_state)
          HUNT: begin
            if (w_bit_valid) begin
              r_shift <= w_shift_next;
              if (w_shift_next == SYNC_WORD) begin
                r_state  <= LEN;
                r_busy   <= 1'b1;
                r_bitcnt <= '0;
                r_csum   <= '0;
              end
            end
          end

          LEN, PAYLOAD, CSUM: begin
            if (w_timeout) begin
              r_eof      <= 1'b1;
              r_err_code <= ERR_TIMEOUT;
              r_state    <= HUNT;
              r_busy     <= 1'b0;
              r_shift    <= '0;
            end else if (w_byte_done) begin
              case (r_state)
                LEN: begin
                  r_remain <= w_byte_next;
                  r_csum   <= w_byte_next;
                  if (w_byte_next > LEN_MAX) begin
                    r_eof      <= 1'b1;
                    r_err_code <= ERR_LEN;
                    r_state    <= HUNT;
                    r_busy     <= 1'b0;
                    r_shift    <= '0;
                  end else begin
                    r_sof   <= 1'b1;
                    r_state <= (w_byte_next == '0) ? CSUM : PAYLOAD;
                  end
                end

                PAYLOAD: begin
                  r_data   <= w_byte_next;
                  r_valid  <= 1'b1;
                  r_csum   <= r_csum + w_byte_next;
                  r_remain <= r_remain - 8'd1;
                  if (r_remain == 8'd1) begin
                    r_state <= CSUM;
                  end
                end

                CSUM: begin
                  r_eof   <= 1'b1;
                  r_state <= HUNT;
                  r_busy  <= 1'b0;
                  // Cleared so leftover payload bits cannot complete a sync word
                  r_shift <= '0;
                  if (w_byte_next == r_csum) begin
                    r_frame_ok <= 1'b1;
                  end else begin
                    r_err_code <= ERR_CSUM;
                  end
                end

                default: begin
                  r_state <= HUNT;
                end
              endcase
            end
          end

          default: begin
            r_state <= HUNT;
          end
        endcase
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign rx_sof      = r_sof;
  assign rx_eof      = r_eof;
  assign rx_frame_ok = r_frame_ok;
  assign rx_err_code = r_err_code;
  assign rx_busy     = r_busy;

endmodule

// File: tb/tb_ook_rx_deframer.sv
// Scoreboard bench for ook_rx_deframer: stimulus pushes expected events,
// a monitor pops and compares on every sof/valid/eof pulse.
module tb_ook_rx_deframer;

  localparam logic [1:0] K_SOF  = 2'd0;
  localparam logic [1:0] K_BYTE = 2'd1;
  localparam logic [1:0] K_EOF  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       ok;
    logic [1:0] code;
  } ev_t;

  logic       clk_system = 1'b0;
  logic       g_reset_n  = 1'b0;
  logic       enable     = 1'b0;
  logic       rx_in      = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_frame_ok;
  logic [1:0] rx_err_code;
  logic       rx_busy;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  bit  jitter   = 1'b0;
  bit  glitch   = 1'b0;
  bit  jit_long = 1'b0;
  bit  busy_chk_pending = 1'b0;
  ev_t        mon_e;
  logic [1:0] mon_k;

  always #8 clk_system = ~clk_system;

  ook_rx_deframer #(
    .OVERSAMPLE   (8),
    .SYNC_WORD    (16'hA5C3),
    .MAX_LEN      (64),
    .TIMEOUT_BITS (32)
  ) dut (
    .clk_system  (clk_system),
    .g_reset_n   (g_reset_n),
    .enable      (enable),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_sof      (rx_sof),
    .rx_eof      (rx_eof),
    .rx_frame_ok (rx_frame_ok),
    .rx_err_code (rx_err_code),
    .rx_busy     (rx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({rx_data, rx_valid, rx_sof, rx_eof, rx_frame_ok, rx_err_code, rx_busy});
  endfunction

  task automatic push(input logic [1:0] k, input logic [7:0] d, input logic ok, input logic [1:0] code);
    ev_t e;
    e.kind = k; e.data = d; e.ok = ok; e.code = code;
    exp_q.push_back(e);
  endtask

  // Jitter alternates 7/9 clocks per bit; glitch inverts clock 6 of each bit
  task automatic send_bit(input logic v);
    int len;
    if (jitter) begin
      len = jit_long ? 9 : 7;
      jit_long = ~jit_long;
    end else begin
      len = 8;
    end
    for (int i = 0; i < len; i++) begin
      rx_in = (glitch && i == 6) ? ~v : v;
      @(posedge clk_system); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_sync();
    send_byte(8'hA5);
    send_byte(8'hC3);
  endtask

  task automatic idle(input int nbits);
    rx_in = 1'b0;
    repeat (nbits * 8) @(posedge clk_system);
    #1;
  endtask

  task automatic drained(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // 03, 11 22 33, checksum 03+11+22+33 = 69
  task automatic good_frame();
    push(K_SOF, 8'h00, 1'b0, 2'd0);
    push(K_BYTE, 8'h11, 1'b0, 2'd0);
    push(K_BYTE, 8'h22, 1'b0, 2'd0);
    push(K_BYTE, 8'h33, 1'b0, 2'd0);
    push(K_EOF, 8'h00, 1'b1, 2'd0);
    send_sync();
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
  endtask

  // Partial frame: sof and byte 11 delivered, then 4 bits of 22 in flight
  task automatic partial_frame();
    push(K_SOF, 8'h00, 1'b0, 2'd0);
    push(K_BYTE, 8'h11, 1'b0, 2'd0);
    send_sync();
    send_byte(8'h03); send_byte(8'h11);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
  endtask

  // Monitor: compare every output pulse against the scoreboard head
  always @(negedge clk_system) begin
    if (busy_chk_pending) begin
      chk("busy_after_len_err", 32'(rx_busy), 32'd0);
      busy_chk_pending = 1'b0;
    end
    if (rx_sof || rx_valid || rx_eof) begin
      mon_k = rx_eof ? K_EOF : (rx_sof ? K_SOF : K_BYTE);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got kind %0d data %0h, expected none at %0t",
                 mon_k, rx_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", 32'(mon_k), 32'(mon_e.kind));
        if (mon_e.kind == K_BYTE) chk("rx_data", 32'(rx_data), 32'(mon_e.data));
        if (mon_e.kind == K_EOF) begin
          chk("rx_frame_ok", 32'(rx_frame_ok), 32'(mon_e.ok));
          chk("rx_err_code", 32'(rx_err_code), 32'(mon_e.code));
          if (mon_e.code == 2'd1) busy_chk_pending = 1'b1;
        end else begin
          chk("status_without_eof", 32'({rx_frame_ok, rx_err_code}), 32'd0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk_system);
    @(negedge clk_system);
    chk("reset_outputs", all_outs(), 32'd0);
    @(posedge clk_system); #1;
    g_reset_n = 1'b1;
    enable    = 1'b1;
    idle(6);

    // Good frame at 8 clocks per bit
    good_frame();
    idle(6);
    drained("drained_good");

    // Bad checksum: bytes still delivered, eof with code 2
    push(K_SOF, 8'h00, 1'b0, 2'd0);
    push(K_BYTE, 8'h11, 1'b0, 2'd0);
    push(K_BYTE, 8'h22, 1'b0, 2'd0);
    push(K_BYTE, 8'h33, 1'b0, 2'd0);
    push(K_EOF, 8'h00, 1'b0, 2'd2);
    send_sync();
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h68);
    idle(6);
    drained("drained_csum");

    // Length 0x41 = 65 exceeds MAX_LEN: no sof, eof code 1, then a good frame
    push(K_EOF, 8'h00, 1'b0, 2'd1);
    send_sync();
    send_byte(8'h41);
    idle(6);
    drained("drained_len");
    good_frame();
    idle(6);
    drained("drained_after_len");

    // Timeout: line low after 11 22. The zeros still form three 00 bytes,
    // then the 32nd bit after the last edge lands inside the checksum byte.
    push(K_SOF, 8'h00, 1'b0, 2'd0);
    push(K_BYTE, 8'h11, 1'b0, 2'd0);
    push(K_BYTE, 8'h22, 1'b0, 2'd0);
    push(K_BYTE, 8'h00, 1'b0, 2'd0);
    push(K_BYTE, 8'h00, 1'b0, 2'd0);
    push(K_BYTE, 8'h00, 1'b0, 2'd0);
    push(K_EOF, 8'h00, 1'b0, 2'd3);
    send_sync();
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    idle(44);
    drained("drained_timeout");

    // Jittered 7/9 bit periods with a one-clock glitch in every bit
    jitter = 1'b1; glitch = 1'b1; jit_long = 1'b0;
    good_frame();
    jitter = 1'b0; glitch = 1'b0;
    idle(6);
    drained("drained_jitter");

    // Enable dropped for 3 cycles mid-payload
    partial_frame();
    @(negedge clk_system);
    chk("busy_mid_frame", 32'(rx_busy), 32'd1);
    @(posedge clk_system); #1;
    enable = 1'b0;
    repeat (2) @(posedge clk_system);
    @(negedge clk_system);
    chk("disabled_outputs", all_outs(), 32'd0);
    @(posedge clk_system); #1;
    enable = 1'b1;
    idle(30);
    drained("drained_enable");
    good_frame();
    idle(6);
    drained("drained_after_enable");

    // Asynchronous reset pulsed mid-payload
    partial_frame();
    @(negedge clk_system);
    chk("busy_before_reset", 32'(rx_busy), 32'd1);
    g_reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", all_outs(), 32'd0);
    repeat (3) @(posedge clk_system);
    #1;
    g_reset_n = 1'b1;
    idle(30);
    chk("busy_after_reset", 32'(rx_busy), 32'd0);
    drained("drained_reset");
    good_frame();
    idle(6);
    drained("drained_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
